// File: rtl/ring_johnson_counter.sv
// WIDTH-bit shift-register counter running as a one-hot ring or a Johnson
// (twisted-ring) counter, with load, direction, illegal-state recovery and wrap pulse.
module ring_johnson_counter #(
  parameter int  WIDTH = 4,
  localparam int PW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    position,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] SEED  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES  = '1;
  localparam logic [PW-1:0]    RING_LAST = PW'(WIDTH - 1);
  localparam logic [PW-1:0]    JOHN_LAST = PW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  logic             ring_legal, john_legal;
  logic [PW-1:0]    ring_pos, john_pos;
  logic [PW-1:0]    last_idx;

  // Decode both interpretations of the register; mode selects which one is reported.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ring_legal = 1'b0;
    ring_pos   = '0;
    john_legal = 1'b0;
    john_pos   = '0;

    for (int i = 0; i < WIDTH; i++) begin
      if (count_q == (SEED << i)) begin
        ring_legal = 1'b1;
        ring_pos   = PW'(i);
      end
    end

    if (count_q == '0) john_legal = 1'b1;
    for (int k = 1; k <= WIDTH; k++) begin
      if (count_q == (ONES >> (WIDTH - k))) begin
        john_legal = 1'b1;
        john_pos   = PW'(k);
      end
    end
    for (int k = 1; k < WIDTH; k++) begin
      if (count_q == ~(ONES >> (WIDTH - k))) begin
        john_legal = 1'b1;
        john_pos   = PW'(WIDTH + k);
      end
    end
  end

  assign illegal  = mode ? ~john_legal : ~ring_legal;
  assign position = illegal ? '0 : (mode ? john_pos : ring_pos);
  assign last_idx = mode ? JOHN_LAST : RING_LAST;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (illegal) begin
        count_d = SEED;
      end else begin
        unique case ({mode, dir})
          2'b00: count_d = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
          2'b01: count_d = {count_q[0], count_q[WIDTH-1:1]};
          2'b10: count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
          2'b11: count_d = {~count_q[0], count_q[WIDTH-1:1]};
          default: count_d = SEED;
        endcase
        wrap_d = dir ? (position == '0) : (position == last_idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      count_q <= SEED;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed self-checking bench for ring_johnson_counter at WIDTH = 4.
module tb_ring_johnson_counter;

  logic       clk = 1'b0;
  logic       reset, en, dir, mode, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic [2:0] position;
  logic       wrap, illegal;

  int n_cmp = 0;
  int n_err = 0;

  ring_johnson_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .position (position),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic [2:0] p,
                           input logic w, input logic ill);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".position"}, 32'(position), 32'(p));
    check({tag, ".wrap"}, 32'(wrap), 32'(w));
    check({tag, ".illegal"}, 32'(illegal), 32'(ill));
  endtask

  logic [3:0] ring_up_cnt [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [2:0] ring_up_pos [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
  logic       ring_up_wrp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic [3:0] jup_cnt [8] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
  logic [2:0] jup_pos [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  logic       jup_wrp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [3:0] jdn_cnt [8] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
  logic [2:0] jdn_pos [8] = '{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
  logic       jdn_wrp [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
    #1;
    check_all("reset_ring", 4'b0001, 3'd0, 1'b0, 1'b0);
    mode = 1'b1;
    #1;
    check("reset_john.position", 32'(position), 32'd1);
    check("reset_john.illegal", 32'(illegal), 32'd0);
    mode = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Hold with en low after release.
    step();
    check_all("hold0", 4'b0001, 3'd0, 1'b0, 1'b0);

    // Ring up through a full cycle.
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_all($sformatf("ring_up%0d", i), ring_up_cnt[i], ring_up_pos[i],
                ring_up_wrp[i], 1'b0);
    end

    // Hold drops the wrap pulse.
    en = 1'b0;
    step();
    check_all("ring_hold", 4'b0001, 3'd0, 1'b0, 1'b0);

    // Ring down: wrap on 0 -> 3, then normal step.
    dir = 1'b1; en = 1'b1;
    step();
    check_all("ring_dn0", 4'b1000, 3'd3, 1'b1, 1'b0);
    step();
    check_all("ring_dn1", 4'b0100, 3'd2, 1'b0, 1'b0);
    en = 1'b0;
    step();
    check_all("ring_dn_hold", 4'b0100, 3'd2, 1'b0, 1'b0);
    en = 1'b1;
    step();
    check_all("ring_dn2", 4'b0010, 3'd1, 1'b0, 1'b0);
    dir = 1'b0;
    step();
    check_all("ring_dirflip", 4'b0100, 3'd2, 1'b0, 1'b0);

    // Switch to Johnson with an illegal pattern, then recover.
    en = 1'b0; mode = 1'b1;
    #1;
    check("mode_sw.illegal", 32'(illegal), 32'd1);
    check("mode_sw.position", 32'(position), 32'd0);
    en = 1'b1;
    step();
    check_all("john_recover", 4'b0001, 3'd1, 1'b0, 1'b0);

    // Johnson up, eight states.
    for (int i = 0; i < 8; i++) begin
      step();
      check_all($sformatf("john_up%0d", i), jup_cnt[i], jup_pos[i], jup_wrp[i], 1'b0);
    end

    // Johnson down, eight states.
    dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_all($sformatf("john_dn%0d", i), jdn_cnt[i], jdn_pos[i], jdn_wrp[i], 1'b0);
    end

    // Load wins over en and is accepted even when illegal.
    mode = 1'b0; dir = 1'b0; load = 1'b1; load_val = 4'b0101;
    step();
    check_all("load", 4'b0101, 3'd0, 1'b0, 1'b1);
    load = 1'b0;
    step();
    check_all("load_recover", 4'b0001, 3'd0, 1'b0, 1'b0);

    // Reach 1000 and apply async reset between edges.
    step(); step(); step();
    check("pre_reset.count", 32'(count), 32'h8);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all("async_rst", 4'b0001, 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step();
    check_all("post_rst", 4'b0010, 3'd1, 1'b0, 1'b0);

    // Reset kills a wrap pulse in flight.
    step(); step(); step();
    check_all("wrap_again", 4'b0001, 3'd0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_kills_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
